// File: rtl/alu_share_arb_if.sv
// Request, ALU and response bundle for alu_share_arb.
interface alu_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [4*NREQ-1:0]  req_op;
  logic [64*NREQ-1:0] req_a;
  logic [64*NREQ-1:0] req_b;

  logic [63:0]        alu_BusA;
  logic [63:0]        alu_BusB;
  logic [3:0]         alu_ALUCtrl;
  logic [63:0]        alu_BusW;
  logic               alu_Zero;

  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [63:0]        resp_data;
  logic               resp_zero;
  logic               resp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, alu_BusW, alu_Zero,
    input  req_ready, alu_BusA, alu_BusB, alu_ALUCtrl,
    input  resp_valid, resp_id, resp_data, resp_zero, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, alu_BusW, alu_Zero,
    output req_ready, alu_BusA, alu_BusB, alu_ALUCtrl,
    output resp_valid, resp_id, resp_data, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one combinational 64-bit ALU: registered issue stage
// feeding the ALU, response register capturing its result with the requester ID.
module alu_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic              CLK,
  input logic              resetl,
  alu_share_arb_if.slave   bus
);

  logic           r_iss_valid;
  logic [3:0]     r_iss_op;
  logic [63:0]    r_iss_a;
  logic [63:0]    r_iss_b;
  logic [IDW-1:0] r_iss_id;
  logic [IDW-1:0] r_ptr;

  logic           r_resp_valid;
  logic [IDW-1:0] r_resp_id;
  logic [63:0]    r_resp_data;
  logic           r_resp_zero;
  logic           r_resp_err;

  logic           w_resp_adv;
  logic           w_iss_adv;
  logic           w_iss_legal;
  logic           w_grant_vld;
  logic [IDW-1:0] w_grant_id;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_cand;
  logic           w_accept;
  logic [3:0]     w_sel_op;
  logic [63:0]    w_sel_a;
  logic [63:0]    w_sel_b;

  assign w_resp_adv  = ~r_resp_valid | bus.resp_ready;
  assign w_iss_adv   = ~r_iss_valid | w_resp_adv;
  assign w_iss_legal = r_iss_op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};

  // Search starts one past the last accepted requester and wraps modulo NREQ.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_sum       = '0;
    w_cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NREQ)) begin
        w_sum = w_sum - (IDW+1)'(NREQ);
      end
      w_cand = w_sum[IDW-1:0];
      if (!w_grant_vld && bus.req_valid[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_cand;
      end
    end
  end

  assign w_accept = w_iss_adv & w_grant_vld;

  always_comb begin
    bus.req_ready = '0;
    if (resetl && w_accept) begin
      bus.req_ready[w_grant_id] = 1'b1;
    end
  end

  assign w_sel_op = bus.req_op[{w_grant_id, 2'b00} +: 4];
  assign w_sel_a  = bus.req_a[{w_grant_id, 6'd0} +: 64];
  assign w_sel_b  = bus.req_b[{w_grant_id, 6'd0} +: 64];

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_iss_valid <= 1'b0;
      r_iss_op    <= '0;
      r_iss_a     <= '0;
      r_iss_b     <= '0;
      r_iss_id    <= '0;
      r_ptr       <= IDW'(NREQ-1);
    end else if (w_iss_adv) begin
      if (w_grant_vld) begin
        r_iss_valid <= 1'b1;
        r_iss_op    <= w_sel_op;
        r_iss_a     <= w_sel_a;
        r_iss_b     <= w_sel_b;
        r_iss_id    <= w_grant_id;
        r_ptr       <= w_grant_id;
      end else begin
        r_iss_valid <= 1'b0;
      end
    end
  end

  // Idle drives zeros; illegal ops are steered to PassB so the ALU never holds.
  always_comb begin
    bus.alu_BusA    = '0;
    bus.alu_BusB    = '0;
    bus.alu_ALUCtrl = 4'b0000;
    if (r_iss_valid) begin
      bus.alu_BusA    = r_iss_a;
      bus.alu_BusB    = r_iss_b;
      bus.alu_ALUCtrl = w_iss_legal ? r_iss_op : 4'b0111;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
      r_resp_zero  <= 1'b0;
      r_resp_err   <= 1'b0;
    end else if (w_resp_adv) begin
      r_resp_valid <= r_iss_valid;
      r_resp_id    <= r_iss_id;
      if (w_iss_legal) begin
        r_resp_data <= bus.alu_BusW;
        r_resp_zero <= bus.alu_Zero;
        r_resp_err  <= 1'b0;
      end else begin
        r_resp_data <= '0;
        r_resp_zero <= 1'b1;
        r_resp_err  <= 1'b1;
      end
    end
  end

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_zero  = r_resp_zero;
  assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural 64-bit ALU on the ALU port.
module tb_alu_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic CLK = 1'b0;
  logic resetl;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .CLK    (CLK),
    .resetl (resetl),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  // External ALU: undefined codes give a marker value so misuse is visible.
  always_comb begin
    bus.alu_BusW = 64'hDEAD_BEEF_DEAD_BEEF;
    case (bus.alu_ALUCtrl)
      4'b0000: bus.alu_BusW = bus.alu_BusA & bus.alu_BusB;
      4'b0001: bus.alu_BusW = bus.alu_BusA | bus.alu_BusB;
      4'b0010: bus.alu_BusW = bus.alu_BusA + bus.alu_BusB;
      4'b0110: bus.alu_BusW = bus.alu_BusA - bus.alu_BusB;
      4'b0111: bus.alu_BusW = bus.alu_BusB;
      default: ;
    endcase
    bus.alu_Zero = (bus.alu_BusW == 64'd0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] i, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b);
    bus.req_op[{i, 2'b00} +: 4] = op;
    bus.req_a[{i, 6'd0} +: 64]  = a;
    bus.req_b[{i, 6'd0} +: 64]  = b;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic [1:0] id, input logic [63:0] data,
                          input logic zero, input logic err);
    chk({tag, "_valid"}, 64'(bus.resp_valid), 64'd1);
    chk({tag, "_id"},    64'(bus.resp_id),    64'(id));
    chk({tag, "_data"},  bus.resp_data,       data);
    chk({tag, "_zero"},  64'(bus.resp_zero),  64'(zero));
    chk({tag, "_err"},   64'(bus.resp_err),   64'(err));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetl         = 1'b0;
    bus.req_valid  = 4'b1111;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    #2;
    chk("rst_ready",      64'(bus.req_ready),  64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_id",    64'(bus.resp_id),    64'd0);
    chk("rst_resp_data",  bus.resp_data,       64'd0);
    chk("rst_resp_zero",  64'(bus.resp_zero),  64'd0);
    chk("rst_resp_err",   64'(bus.resp_err),   64'd0);
    chk("rst_alu_ctrl",   64'(bus.alu_ALUCtrl), 64'd0);
    step();
    step();
    resetl        = 1'b1;
    bus.req_valid = 4'b0000;
    step();

    // Round-robin: every requester SUB i-i, expect ids 0,1,2,3,... one per cycle.
    for (int i = 0; i < NREQ; i++) set_req(2'(i), 4'b0110, 64'(i), 64'(i));
    bus.req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("rr_ready_%0d", c), 64'(bus.req_ready), 64'(4'b0001 << (c % 4)));
      step();
      if (c == 0) begin
        chk("rr_first_empty", 64'(bus.resp_valid), 64'd0);
      end else begin
        chk_resp($sformatf("rr_%0d", c), 2'((c - 1) % 4), 64'd0, 1'b1, 1'b0);
      end
    end
    bus.req_valid = 4'b0000;
    step();
    chk_resp("rr_last", 2'd3, 64'd0, 1'b1, 1'b0);
    step();
    chk("rr_drain", 64'(bus.resp_valid), 64'd0);

    // Single op: req0 ADD 5+7.
    set_req(2'd0, 4'b0010, 64'd5, 64'd7);
    bus.req_valid = 4'b0001;
    #1;
    chk("single_ready", 64'(bus.req_ready), 64'd1);
    step();
    bus.req_valid = 4'b0000;
    chk("single_iss_a",    bus.alu_BusA,         64'd5);
    chk("single_iss_ctrl", 64'(bus.alu_ALUCtrl), 64'd2);
    chk("single_not_yet",  64'(bus.resp_valid),  64'd0);
    step();
    chk_resp("single", 2'd0, 64'd12, 1'b0, 1'b0);
    step();
    chk("single_drain", 64'(bus.resp_valid), 64'd0);

    // Back-pressure: three ops from req2 with the consumer stalled.
    bus.resp_ready = 1'b0;
    set_req(2'd2, 4'b0001, 64'hF0, 64'h0F);
    bus.req_valid = 4'b0100;
    #1;
    chk("bp_ready_1", 64'(bus.req_ready), 64'h4);
    step();
    set_req(2'd2, 4'b0000, 64'hFF, 64'h0F);
    #1;
    chk("bp_ready_2", 64'(bus.req_ready), 64'h4);
    step();
    set_req(2'd2, 4'b0111, 64'd0, 64'h1234);
    for (int s = 0; s < 4; s++) begin
      #1;
      chk_resp($sformatf("bp_hold_%0d", s), 2'd2, 64'hFF, 1'b0, 1'b0);
      chk($sformatf("bp_stall_ready_%0d", s), 64'(bus.req_ready), 64'd0);
      chk($sformatf("bp_stall_alu_a_%0d", s), bus.alu_BusA, 64'hFF);
      if (s < 3) step();
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 64'(bus.req_ready), 64'h4);
    step();
    bus.req_valid = 4'b0000;
    chk_resp("bp_second", 2'd2, 64'h0F, 1'b0, 1'b0);
    step();
    chk_resp("bp_third", 2'd2, 64'h1234, 1'b0, 1'b0);
    step();
    chk("bp_drain", 64'(bus.resp_valid), 64'd0);

    // Illegal op from req1.
    set_req(2'd1, 4'b1111, 64'd3, 64'd4);
    bus.req_valid = 4'b0010;
    #1;
    chk("ill_ready", 64'(bus.req_ready), 64'h2);
    step();
    bus.req_valid = 4'b0000;
    chk("ill_alu_ctrl", 64'(bus.alu_ALUCtrl), 64'h7);
    chk("ill_alu_b",    bus.alu_BusB,         64'd4);
    step();
    chk_resp("ill", 2'd1, 64'd0, 1'b1, 1'b1);
    step();

    // Modulo-2^64 wrap, two back-to-back ops from req0.
    set_req(2'd0, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    bus.req_valid = 4'b0001;
    #1;
    chk("wrap_ready_1", 64'(bus.req_ready), 64'h1);
    step();
    set_req(2'd0, 4'b0110, 64'd0, 64'd1);
    #1;
    chk("wrap_ready_2", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = 4'b0000;
    chk_resp("wrap_add", 2'd0, 64'd0, 1'b1, 1'b0);
    step();
    chk_resp("wrap_sub", 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    step();

    // Reset mid-flight with both stages full (req2 leaves ptr at 2).
    set_req(2'd2, 4'b0010, 64'd1, 64'd1);
    bus.req_valid = 4'b0100;
    step();
    set_req(2'd2, 4'b0010, 64'd2, 64'd2);
    step();
    bus.req_valid = 4'b0000;
    chk_resp("mid_full", 2'd2, 64'd2, 1'b0, 1'b0);
    chk("mid_iss_a", bus.alu_BusA, 64'd2);
    #2;
    resetl = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.resp_valid), 64'd0);
    chk("mid_rst_data",  bus.resp_data,       64'd0);
    chk("mid_rst_id",    64'(bus.resp_id),    64'd0);
    chk("mid_rst_alu_a", bus.alu_BusA,        64'd0);
    #2;
    resetl = 1'b1;
    step();
    chk("mid_after_1", 64'(bus.resp_valid), 64'd0);
    step();
    chk("mid_after_2", 64'(bus.resp_valid), 64'd0);
    bus.req_valid = 4'b1111;
    #1;
    chk("mid_grant0", 64'(bus.req_ready), 64'h1);
    bus.req_valid = 4'b0000;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and two-stage issue/response pipeline that shares the datapath's single combinational 64-bit ALU (opcodes AND/OR/ADD/SUB/PassB) among several requesters (e.g. address-generation, branch-compare and debug ports). It accepts one request per cycle and drives the ALU's BusA/BusB/ALUCtrl from a registered issue stage. It captures BusW/Zero into a response register with the requester's ID and applies valid/ready back-pressure end to end.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester-ID width, equal to ceil(log2(NREQ))
- CLK  in  1  single clock; all state updates on the rising edge
- resetl  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_op  in  4*NREQ  per-requester ALUCtrl code, requester i at [4i+3:4i]
- req_a  in  64*NREQ  per-requester operand A
- req_b  in  64*NREQ  per-requester operand B
- alu_BusA  out  64  to ALU BusA
- alu_BusB  out  64  to ALU BusB
- alu_ALUCtrl  out  4  to ALU ALUCtrl
- alu_BusW  in  64  from ALU result
- alu_Zero  in  1  from ALU Zero
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumer ready
- resp_id  out  IDW  index of the requester that issued this response
- resp_data  out  64  result
- resp_zero  out  1  result==0 flag
- resp_err  out  1  illegal opcode flag

## Operation
- Legal opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PassB. Any other code is illegal.
- Issue register holds iss_valid, op, a, b, id, and drives alu_* directly.
- When iss_valid=0, drive alu_BusA=0, alu_BusB=0, alu_ALUCtrl=0000. This keeps the ALU output deterministic and stops it latching.
- When iss_valid=1 with an illegal op, drive alu_ALUCtrl=0111 (PassB) so the ALU's default hold path is never exercised.
- Response register holds resp_valid, resp_id, resp_data, resp_zero, resp_err.
- Flow control:
  - resp_adv = ~resp_valid | resp_ready
  - iss_adv = ~iss_valid | resp_adv
- Arbitration (combinational):
  - When iss_adv=1, grant the first i with req_valid[i]=1, searching from (ptr+1) mod NREQ upward with wrap.
  - req_ready[i]=1 only for the granted i. req_ready may depend combinationally on req_valid.
  - When iss_adv=0, all req_ready=0.
- Accept: when req_valid[i] & req_ready[i], load the issue register with requester i's op/a/b and id=i, and set ptr<=i.
  - ptr changes only on an accept.
- Advance without a new request: if iss_adv=1 and no request is granted, set iss_valid<=0.
- Capture:
  - When resp_adv=1, load the response register from the issue stage: resp_valid<=iss_valid, resp_id<=id.
  - Legal op: resp_data<=alu_BusW, resp_zero<=alu_Zero, resp_err<=0.
  - Illegal op: resp_data<=0, resp_zero<=1, resp_err<=1.
- Responses return in acceptance order. There are no reordering or ID gaps.
- Width: results are exactly 64 bits and ADD/SUB wrap modulo 2^64. The arbiter adds no carry or overflow reporting.

## Timing
- Reset (resetl=0, asynchronous) sets:
  - iss_valid=0, resp_valid=0
  - resp_id=0, resp_data=0, resp_zero=0, resp_err=0
  - ptr=NREQ-1, so requester 0 has first priority
  - all req_ready=0 while resetl=0
- Reset mid-operation discards both pipeline stages. No response is produced for ops in flight.
- Latency: a request accepted at edge k appears in the issue stage after k and gives resp_valid=1 after edge k+1. This is 2 cycles from accept to response.
- Throughput is one op per cycle while resp_ready=1.
- The response register holds all resp_* fields stable while resp_valid=1 and resp_ready=0.
- The issue stage also holds, so alu_* are stable and no req_ready is asserted.
- Stall plus resume: when resp_ready rises, the held response retires and the issue stage moves into the response register on the same edge. A new request may be accepted on that edge too, so there are no bubbles.
- Fairness: a requester holding req_valid=1 is granted within NREQ accepts.

## Test plan
- Single op: req0 ADD a=5, b=7, resp_ready=1 -> req_ready[0]=1 in the accept cycle, then 2 cycles later resp_valid=1, resp_id=0, resp_data=12, resp_zero=0, resp_err=0.
- Round-robin: all 4 requesters valid every cycle, each with SUB a=i, b=i -> resp_id sequence 0,1,2,3,0,..., each with resp_data=0 and resp_zero=1, one response per cycle.
- Back-pressure: 3 back-to-back ops from req2 (OR 0xF0|0x0F, AND 0xFF&0x0F, PassB b=0x1234), resp_ready=0 for 4 cycles and then 1 -> first response held stable at 0xFF, req_ready=0 during the stall, then 0x0F and 0x1234 arrive in order with no loss or duplication.
- Illegal op: req1 op=1111, a=3, b=4 -> resp_err=1, resp_data=0, resp_zero=1, alu_ALUCtrl=0111 while that op is in the issue stage.
- Wrap: ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> resp_data=0, resp_zero=1. SUB a=0, b=1 -> resp_data=0xFFFF_FFFF_FFFF_FFFF.
- Reset mid-flight: two ops in the pipeline, pulse resetl low for a partial cycle -> outputs go to reset values immediately, no response appears afterwards, and the next grant goes to requester 0.
